// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle sequencer: opcodes, ALU codes,
// sequencer states and the strobe bundle driven into the datapath.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_BRX  = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  localparam logic [4:0] ALU_NONE = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd5;
  localparam logic [4:0] ALU_OR   = 5'd6;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef struct packed {
    logic [4:0] alu_op;
    logic read, write, inc_pc;
    logic gra, grb, grc, r_in, r_out, ba_out;
    logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, con_in, outport_in;
    logic pc_out, mdr_out, zlow_out, zhigh_out, hi_out, lo_out, inport_out, c_out;
  } ctl_t;

  // Last execute state of each instruction; the sequencer returns to T0 after it.
  function automatic state_t final_state(input logic [4:0] op);
    if (op == OP_LD || op == OP_ST) return S_T7;
    if (op <= OP_ORI)               return S_T5;  // ldi, R-type, immediates
    if (op <= OP_DIV)               return S_T6;  // mul, div
    if (op <= OP_NOT)               return S_T4;  // neg, not
    if (op == OP_BRX)               return S_T6;
    return S_T3;                                  // single-step and undefined
  endfunction

  // Opcodes with no defined behaviour.
  function automatic logic op_undef(input logic [4:0] op);
    return (op == 5'd20) || (op >= 5'd27);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational strobe decode: (state, opcode, branch flag) -> control bundle.
// RST/HALT and any unlisted state/opcode pair decode to all-zero strobes.
module control_decode
  import cpu_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] op,
  input  logic       con_ff,
  output ctl_t       ctl
);

  logic is_mem, is_r, is_imm, is_md, is_un;

  assign is_mem = (op <= OP_ST);
  assign is_r   = (op >= OP_ADD) && (op <= OP_ROL);
  assign is_imm = (op >= OP_ADDI) && (op <= OP_ORI);
  assign is_md  = (op == OP_MUL) || (op == OP_DIV);
  assign is_un  = (op == OP_NEG) || (op == OP_NOT);

  // One strobe set per state; at most one bus driver in any branch.
  always_comb begin
    ctl = '0;
    case (state)
      S_T0: begin
        ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; ctl.z_in = 1'b1;
        ctl.alu_op = ALU_ADD;
      end
      S_T1: begin
        ctl.zlow_out = 1'b1; ctl.pc_in = 1'b1; ctl.read = 1'b1; ctl.mdr_in = 1'b1;
      end
      S_T2: begin
        ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1;
      end
      S_T3: begin
        if (is_mem) begin
          ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1;
        end else if (is_r || is_imm) begin
          ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1;
        end else if (is_md) begin
          ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1;
        end else if (is_un) begin
          ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; ctl.alu_op = op;
        end else begin
          case (op)
            OP_BRX:  begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_in = 1'b1; end
            OP_JR:   begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1; end
            OP_IN:   begin ctl.inport_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
            OP_OUT:  begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.outport_in = 1'b1; end
            OP_MFHI: begin ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
            OP_MFLO: begin ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
            default: ;  // nop, halt, undefined: no strobes
          endcase
        end
      end
      S_T4: begin
        if (is_mem) begin
          ctl.c_out = 1'b1; ctl.z_in = 1'b1; ctl.alu_op = ALU_ADD;
        end else if (is_r) begin
          ctl.grc = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; ctl.alu_op = op;
        end else if (is_md) begin
          ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; ctl.alu_op = op;
        end else if (is_imm) begin
          ctl.c_out = 1'b1; ctl.z_in = 1'b1;
          ctl.alu_op = (op == OP_ADDI) ? ALU_ADD : (op == OP_ANDI) ? ALU_AND : ALU_OR;
        end else if (is_un) begin
          ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
        end else if (op == OP_BRX) begin
          ctl.pc_out = 1'b1; ctl.y_in = 1'b1;
        end
      end
      S_T5: begin
        if (op == OP_LDI || is_r || is_imm) begin
          ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
        end else if (is_mem) begin
          ctl.zlow_out = 1'b1; ctl.mar_in = 1'b1;
        end else if (is_md) begin
          ctl.zlow_out = 1'b1; ctl.lo_in = 1'b1;
        end else if (op == OP_BRX) begin
          ctl.c_out = 1'b1; ctl.z_in = 1'b1; ctl.alu_op = ALU_ADD;
        end
      end
      S_T6: begin
        if (op == OP_LD) begin
          ctl.read = 1'b1; ctl.mdr_in = 1'b1;
        end else if (op == OP_ST) begin
          ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_in = 1'b1;
        end else if (is_md) begin
          ctl.zhigh_out = 1'b1; ctl.hi_in = 1'b1;
        end else if (op == OP_BRX && con_ff) begin
          ctl.zlow_out = 1'b1; ctl.pc_in = 1'b1;
        end
      end
      S_T7: begin
        if (op == OP_LD) begin
          ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
        end else if (op == OP_ST) begin
          ctl.write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle Moore sequencer for the bus-based datapath.
// Build option CONTROL_UNIT_ILLEGAL_HALT_EN: undefined opcodes raise a sticky
// 'illegal' flag and halt; without it they behave as nop and the port is absent.
module control_unit
  import cpu_pkg::*;
#(
  parameter int RESET_DP_CYCLES = 1
) (
  input  logic        Clock,
  input  logic        clear_n,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
`ifdef CONTROL_UNIT_ILLEGAL_HALT_EN
  output logic        illegal,
`endif
  output logic        Run,
  output logic        dp_clear,
  output logic [4:0]  alu_op,
  output logic        Read,
  output logic        Write,
  output logic        IncPC,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        CONin,
  output logic        Outportin,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIout,
  output logic        LOout,
  output logic        Inportout,
  output logic        Cout
);

  state_t     state;
  logic [4:0] op_q;
  logic [4:0] op;
  logic [3:0] rst_cnt;
  logic       ill_op;
  ctl_t       ctl;

  // Operand fields of IR are consumed by the datapath, not here.
  logic ir_unused;
  assign ir_unused = ^IR[26:0];

  // IR only becomes valid once T2's closing edge loads it, so T3 decodes the
  // live opcode and later states use the copy captured on leaving T3.
  assign op = (state == S_T3) ? IR[31:27] : op_q;

`ifdef CONTROL_UNIT_ILLEGAL_HALT_EN
  logic ill_q;
  assign ill_op  = op_undef(op);
  assign illegal = ill_q;
`else
  assign ill_op  = 1'b0;
`endif

  // Sequencer: one state per clock, reset hold, instruction-boundary halt.
  always_ff @(posedge Clock or negedge clear_n) begin
    if (!clear_n) begin
      state   <= S_RST;
      op_q    <= '0;
      rst_cnt <= '0;
`ifdef CONTROL_UNIT_ILLEGAL_HALT_EN
      ill_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_RST: begin
          if (rst_cnt == 4'(RESET_DP_CYCLES - 1)) state <= S_T0;
          else rst_cnt <= rst_cnt + 4'd1;
        end
        S_T0:   state <= S_T1;
        S_T1:   state <= S_T2;
        S_T2:   state <= S_T3;
        S_HALT: state <= S_HALT;
        default: begin
          if (state == S_T3) op_q <= IR[31:27];
          if (state == S_T3 && (op == OP_HALT || ill_op)) begin
            state <= S_HALT;
`ifdef CONTROL_UNIT_ILLEGAL_HALT_EN
            if (ill_op) ill_q <= 1'b1;
`endif
          end else if (state == final_state(op)) begin
            state <= Stop ? S_HALT : S_T0;
          end else begin
            state <= state_t'(state + 4'd1);
          end
        end
      endcase
    end
  end

  control_decode u_dec (
    .state  (state),
    .op     (op),
    .con_ff (CON_FF),
    .ctl    (ctl)
  );

  assign Run       = (state != S_RST) && (state != S_HALT);
  assign dp_clear  = (state == S_RST);
  assign alu_op    = ctl.alu_op;
  assign Read      = ctl.read;
  assign Write     = ctl.write;
  assign IncPC     = ctl.inc_pc;
  assign Gra       = ctl.gra;
  assign Grb       = ctl.grb;
  assign Grc       = ctl.grc;
  assign Rin       = ctl.r_in;
  assign Rout      = ctl.r_out;
  assign BAout     = ctl.ba_out;
  assign PCin      = ctl.pc_in;
  assign IRin      = ctl.ir_in;
  assign MARin     = ctl.mar_in;
  assign MDRin     = ctl.mdr_in;
  assign Yin       = ctl.y_in;
  assign Zin       = ctl.z_in;
  assign HIin      = ctl.hi_in;
  assign LOin      = ctl.lo_in;
  assign CONin     = ctl.con_in;
  assign Outportin = ctl.outport_in;
  assign PCout     = ctl.pc_out;
  assign MDRout    = ctl.mdr_out;
  assign Zlowout   = ctl.zlow_out;
  assign Zhighout  = ctl.zhigh_out;
  assign HIout     = ctl.hi_out;
  assign LOout     = ctl.lo_out;
  assign Inportout = ctl.inport_out;
  assign Cout      = ctl.c_out;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction-level model (queue of expected strobe
// steps per instruction) compared every cycle, plus literal spot checks.
module tb_control_unit;

  localparam int RDC = 1;

  localparam logic [26:0] M_READ  = 27'd1 << 0;
  localparam logic [26:0] M_WRITE = 27'd1 << 1;
  localparam logic [26:0] M_INC   = 27'd1 << 2;
  localparam logic [26:0] M_GRA   = 27'd1 << 3;
  localparam logic [26:0] M_GRB   = 27'd1 << 4;
  localparam logic [26:0] M_GRC   = 27'd1 << 5;
  localparam logic [26:0] M_RIN   = 27'd1 << 6;
  localparam logic [26:0] M_ROUT  = 27'd1 << 7;
  localparam logic [26:0] M_BAOUT = 27'd1 << 8;
  localparam logic [26:0] M_PCIN  = 27'd1 << 9;
  localparam logic [26:0] M_IRIN  = 27'd1 << 10;
  localparam logic [26:0] M_MARIN = 27'd1 << 11;
  localparam logic [26:0] M_MDRIN = 27'd1 << 12;
  localparam logic [26:0] M_YIN   = 27'd1 << 13;
  localparam logic [26:0] M_ZIN   = 27'd1 << 14;
  localparam logic [26:0] M_HIIN  = 27'd1 << 15;
  localparam logic [26:0] M_LOIN  = 27'd1 << 16;
  localparam logic [26:0] M_CONIN = 27'd1 << 17;
  localparam logic [26:0] M_OPIN  = 27'd1 << 18;
  localparam logic [26:0] M_PCOUT = 27'd1 << 19;
  localparam logic [26:0] M_MDROUT= 27'd1 << 20;
  localparam logic [26:0] M_ZLO   = 27'd1 << 21;
  localparam logic [26:0] M_ZHI   = 27'd1 << 22;
  localparam logic [26:0] M_HIOUT = 27'd1 << 23;
  localparam logic [26:0] M_LOOUT = 27'd1 << 24;
  localparam logic [26:0] M_INPOUT= 27'd1 << 25;
  localparam logic [26:0] M_COUT  = 27'd1 << 26;
  localparam logic [26:0] BUS = M_ROUT | M_BAOUT | M_PCOUT | M_MDROUT | M_ZLO | M_ZHI |
                                M_HIOUT | M_LOOUT | M_INPOUT | M_COUT;
  localparam logic [26:0] FETCH0 = M_PCOUT | M_MARIN | M_INC | M_ZIN;

  logic Clock = 1'b0, clear_n = 1'b1, CON_FF = 1'b0, Stop = 1'b0;
  logic [31:0] IR = '0;
  logic Run, dp_clear, Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, Outportin;
  logic PCout, MDRout, Zlowout, Zhighout, HIout, LOout, Inportout, Cout;
  logic [4:0] alu_op;
`ifdef CONTROL_UNIT_ILLEGAL_HALT_EN
  logic illegal;
`endif

  logic [26:0] obs;
  assign obs = {Cout, Inportout, LOout, HIout, Zhighout, Zlowout, MDRout, PCout, Outportin,
                CONin, LOin, HIin, Zin, Yin, MDRin, MARin, IRin, PCin, BAout, Rout, Rin,
                Grc, Grb, Gra, IncPC, Write, Read};

  always #5 Clock = ~Clock;

  control_unit #(.RESET_DP_CYCLES(RDC)) dut (
    .Clock(Clock), .clear_n(clear_n), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
`ifdef CONTROL_UNIT_ILLEGAL_HALT_EN
    .illegal(illegal),
`endif
    .Run(Run), .dp_clear(dp_clear), .alu_op(alu_op), .Read(Read), .Write(Write),
    .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .CONin(CONin), .Outportin(Outportin), .PCout(PCout),
    .MDRout(MDRout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout), .LOout(LOout),
    .Inportout(Inportout), .Cout(Cout)
  );

  typedef struct { logic [26:0] m; logic [4:0] alu; } step_t;
  typedef struct { logic [31:0] ir; logic con; } instr_t;

  step_t  q[$];
  instr_t prog[$];
  int     vec = 0, bad = 0;
  int     mode = 0;      // 0 reset hold, 1 running, 2 halted
  int     rst_left = 0, k = 0;
  logic [31:0] cur_ir;
  logic   cur_con, cur_halt, cur_ill, ill_exp = 1'b0;
  logic [26:0] last_obs;
  logic [4:0]  last_alu;
  logic   last_run, last_dpc, last_ill;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, exp);
    end
  endtask

  task automatic push(input logic [26:0] m, input logic [4:0] a);
    step_t s;
    s.m = m; s.alu = a;
    q.push_back(s);
  endtask

  // Expected per-cycle strobe list for one whole instruction.
  task automatic build(input logic [4:0] op, input logic con);
    q.delete();
    push(FETCH0, 5'd3);
    push(M_ZLO | M_PCIN | M_READ | M_MDRIN, 5'd0);
    push(M_MDROUT | M_IRIN, 5'd0);
    if (op <= 5'd2) begin
      push(M_GRB | M_BAOUT | M_YIN, 5'd0);
      push(M_COUT | M_ZIN, 5'd3);
      if (op == 5'd1) push(M_ZLO | M_GRA | M_RIN, 5'd0);
      else begin
        push(M_ZLO | M_MARIN, 5'd0);
        if (op == 5'd0) begin
          push(M_READ | M_MDRIN, 5'd0); push(M_MDROUT | M_GRA | M_RIN, 5'd0);
        end else begin
          push(M_GRA | M_ROUT | M_MDRIN, 5'd0); push(M_WRITE, 5'd0);
        end
      end
    end else if (op <= 5'd13) begin
      push(M_GRB | M_ROUT | M_YIN, 5'd0);
      push(((op <= 5'd10) ? (M_GRC | M_ROUT) : M_COUT) | M_ZIN,
           (op <= 5'd10) ? op : (op == 5'd11) ? 5'd3 : (op == 5'd12) ? 5'd5 : 5'd6);
      push(M_ZLO | M_GRA | M_RIN, 5'd0);
    end else if (op <= 5'd15) begin
      push(M_GRA | M_ROUT | M_YIN, 5'd0); push(M_GRB | M_ROUT | M_ZIN, op);
      push(M_ZLO | M_LOIN, 5'd0);          push(M_ZHI | M_HIIN, 5'd0);
    end else if (op <= 5'd17) begin
      push(M_GRB | M_ROUT | M_ZIN, op); push(M_ZLO | M_GRA | M_RIN, 5'd0);
    end else if (op == 5'd18) begin
      push(M_GRA | M_ROUT | M_CONIN, 5'd0); push(M_PCOUT | M_YIN, 5'd0);
      push(M_COUT | M_ZIN, 5'd3);           push(con ? (M_ZLO | M_PCIN) : 27'd0, 5'd0);
    end else begin
      case (op)
        5'd19:   push(M_GRA | M_ROUT | M_PCIN, 5'd0);
        5'd21:   push(M_INPOUT | M_GRA | M_RIN, 5'd0);
        5'd22:   push(M_GRA | M_ROUT | M_OPIN, 5'd0);
        5'd23:   push(M_HIOUT | M_GRA | M_RIN, 5'd0);
        5'd24:   push(M_LOOUT | M_GRA | M_RIN, 5'd0);
        default: push(27'd0, 5'd0);
      endcase
    end
  endtask

  task automatic start_instr();
    instr_t in;
    logic [4:0] op;
    logic undef;
    if (prog.size() > 0) in = prog.pop_front();
    else begin in.ir = $urandom; in.con = 1'($urandom_range(0, 1)); end
    cur_ir = in.ir; cur_con = in.con;
    op = cur_ir[31:27];
    undef = (op == 5'd20) || (op >= 5'd27);
`ifdef CONTROL_UNIT_ILLEGAL_HALT_EN
    cur_ill = undef; cur_halt = (op == 5'd26) || undef;
`else
    cur_ill = 1'b0; cur_halt = (op == 5'd26);
`endif
    build(op, in.con);
    k = 0; mode = 1;
    IR = $urandom;   // IR not yet loaded during fetch
  endtask

  // Called at posedge+1; drives inputs, checks at negedge, advances the model.
  task automatic one_cycle(input logic stop_v);
    step_t e;
    if (mode == 1 && k == 3) begin IR = cur_ir; CON_FF = cur_con; end
    Stop = stop_v;
    e.m = '0; e.alu = '0;
    if (mode == 1) e = q[k];
    @(negedge Clock);
    last_obs = obs; last_alu = alu_op; last_run = Run; last_dpc = dp_clear;
    chk("strobes", 32'(obs), 32'(e.m));
    chk("alu_op", 32'(alu_op), 32'(e.alu));
    chk("Run", 32'(Run), 32'(mode == 1));
    chk("dp_clear", 32'(dp_clear), 32'(mode == 0));
    chk("rd_wr_excl", 32'(Read & Write), 32'd0);
    chk("one_bus_driver", 32'($countones(obs & BUS) > 1), 32'd0);
`ifdef CONTROL_UNIT_ILLEGAL_HALT_EN
    last_ill = illegal;
    chk("illegal", 32'(illegal), 32'(ill_exp));
`else
    last_ill = 1'b0;
`endif
    @(posedge Clock); #1;
    if (mode == 0) begin
      rst_left--;
      if (rst_left == 0) start_instr();
    end else if (mode == 1) begin
      if (k == q.size() - 1) begin
        if (cur_halt) begin mode = 2; ill_exp = ill_exp | cur_ill; end
        else if (stop_v) mode = 2;
        else start_instr();
      end else k++;
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must react without a clock.
  task automatic do_reset();
    #2 clear_n = 1'b0;
    #1;
    chk("rst_strobes", 32'(obs), 32'd0);
    chk("rst_alu", 32'(alu_op), 32'd0);
    chk("rst_run", 32'(Run), 32'd0);
    chk("rst_dp_clear", 32'(dp_clear), 32'd1);
    mode = 0; rst_left = RDC; ill_exp = 1'b0; Stop = 1'b0;
    @(posedge Clock); #1;
    clear_n = 1'b1;
  endtask

  initial begin
    int halt_cnt;
    // ld R2,0xB(R0) then add R1,R2,R3 halted by Stop in T4
    prog.push_back('{32'h0100000B, 1'b0});
    prog.push_back('{{5'd3, 4'd1, 4'd2, 4'd3, 15'd0}, 1'b0});
    do_reset();
    one_cycle(1'b0);
    chk("lit_rst_dpc", 32'(last_dpc), 32'd1);
    chk("lit_rst_obs", 32'(last_obs), 32'd0);
    for (int i = 0; i < 8; i++) begin
      one_cycle(1'b0);
      if (i == 0) begin
        chk("lit_T0_obs", 32'(last_obs), 32'(FETCH0));
        chk("lit_T0_alu", 32'(last_alu), 32'd3);
      end
      if (i == 7) chk("lit_ld_T7", 32'(last_obs), 32'(M_MDROUT | M_GRA | M_RIN));
    end
    for (int i = 0; i < 6; i++) begin
      one_cycle(i >= 4);
      if (i == 0) chk("lit_ld_len8", 32'(last_obs), 32'(FETCH0));
      if (i == 4) begin
        chk("lit_add_T4", 32'(last_obs), 32'(M_GRC | M_ROUT | M_ZIN));
        chk("lit_add_alu", 32'(last_alu), 32'd3);
      end
      if (i == 5) chk("lit_add_T5", 32'(last_obs), 32'(M_ZLO | M_GRA | M_RIN));
    end
    one_cycle(1'b0);
    chk("lit_halt_run", 32'(last_run), 32'd0);

    // brx with CON_FF 0 and 1, then ld interrupted by reset in T4
    prog.push_back('{{5'd18, 27'd0}, 1'b0});
    prog.push_back('{{5'd18, 27'd0}, 1'b1});
    prog.push_back('{32'h0100000B, 1'b0});
    do_reset();
    one_cycle(1'b0);
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 7; i++) begin
        one_cycle(1'b0);
        if (i == 6) chk("lit_brx_T6", 32'(last_obs), (b == 1) ? 32'(M_ZLO | M_PCIN) : 32'd0);
      end
    for (int i = 0; i < 4; i++) one_cycle(1'b0);
    do_reset();

    // opcode 11111
    prog.push_back('{{5'h1f, 27'd0}, 1'b0});
    one_cycle(1'b0);
    for (int i = 0; i < 4; i++) one_cycle(1'b0);
    one_cycle(1'b0);
`ifdef CONTROL_UNIT_ILLEGAL_HALT_EN
    chk("lit_ill_run", 32'(last_run), 32'd0);
    chk("lit_ill_flag", 32'(last_ill), 32'd1);
`else
    chk("lit_undef_T0", 32'(last_obs), 32'(FETCH0));
`endif

    // random instruction stream with random Stop and occasional resets
    halt_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      if (mode == 2) halt_cnt++;
      if (halt_cnt >= 3 || $urandom_range(0, 299) == 0) begin
        halt_cnt = 0;
        do_reset();
      end else begin
        one_cycle($urandom_range(0, 19) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
